// File: rtl/el2_dccm_bank_ram.sv
// el2_dccm_bank_ram: banked DCCM data/ECC array with post-reset zero-init sweep.
// Define EL2_DCCM_ERR_INJ_EN to add a one-shot per-bank read-path bit-flip injector.
module el2_dccm_bank_ram #(
    parameter int DCCM_NUM_BANKS   = 4,
    parameter int DCCM_INDEX_DEPTH = 2048,
    parameter int DCCM_DATA_WIDTH  = 32,
    parameter int DCCM_ECC_WIDTH   = 7
) (
    input  logic                                                        clk,
    input  logic                                                        rst,
    input  logic [DCCM_NUM_BANKS-1:0]                                   i_dccm_clken,
    input  logic [DCCM_NUM_BANKS-1:0]                                   i_dccm_wren_bank,
    input  logic [DCCM_NUM_BANKS-1:0][$clog2(DCCM_INDEX_DEPTH)-1:0]     i_dccm_addr_bank,
    input  logic [DCCM_NUM_BANKS-1:0][DCCM_DATA_WIDTH-1:0]              i_dccm_wr_data_bank,
    input  logic [DCCM_NUM_BANKS-1:0][DCCM_ECC_WIDTH-1:0]               i_dccm_wr_ecc_bank,
`ifdef EL2_DCCM_ERR_INJ_EN
    input  logic                                                        i_err_inj_req,
    input  logic [$clog2(DCCM_NUM_BANKS)-1:0]                           i_err_inj_bank,
    input  logic [$clog2(DCCM_DATA_WIDTH+DCCM_ECC_WIDTH)-1:0]           i_err_inj_bit,
`endif
    output logic [DCCM_NUM_BANKS-1:0][DCCM_DATA_WIDTH-1:0]              o_dccm_bank_dout,
    output logic [DCCM_NUM_BANKS-1:0][DCCM_ECC_WIDTH-1:0]               o_dccm_bank_ecc,
    output logic                                                        o_init_done
);
    localparam int INDEX_BITS = $clog2(DCCM_INDEX_DEPTH);
    localparam int WORD_W     = DCCM_DATA_WIDTH + DCCM_ECC_WIDTH;

    typedef enum logic {INIT, READY} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [INDEX_BITS-1:0]   r_idx;
    logic                    w_ready;
    logic [DCCM_NUM_BANKS-1:0][WORD_W-1:0] w_flip;

    assign w_ready     = r_state == READY;
    assign o_init_done = w_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= INIT;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_ready ? '0 : r_idx + 1'b1;
        end
    end

    // Depth is a power of two, so the last sweep index is all ones.
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == INIT && &r_idx)
            w_state_nxt = READY;
    end

`ifdef EL2_DCCM_ERR_INJ_EN
    logic [DCCM_NUM_BANKS-1:0]                                          r_arm;
    logic [DCCM_NUM_BANKS-1:0][$clog2(WORD_W)-1:0]                      r_bit;

    // A read consumes the arm before a same-cycle request re-arms it.
    always_ff @(posedge clk) begin
        if (rst || !w_ready) begin
            r_arm <= '0;
        end else begin
            for (int i = 0; i < DCCM_NUM_BANKS; i++)
                if (i_dccm_clken[i] && !i_dccm_wren_bank[i])
                    r_arm[i] <= 1'b0;
            if (i_err_inj_req) begin
                r_arm[i_err_inj_bank] <= 1'b1;
                r_bit[i_err_inj_bank] <= i_err_inj_bit;
            end
        end
    end

    always_comb begin
        w_flip = '0;
        for (int i = 0; i < DCCM_NUM_BANKS; i++)
            w_flip[i] = r_arm[i] ? (WORD_W'(1) << r_bit[i]) : '0;
    end
`else
    assign w_flip = '0;
`endif

    for (genvar b = 0; b < DCCM_NUM_BANKS; b++) begin : g_bank
        logic [WORD_W-1:0]     r_mem [DCCM_INDEX_DEPTH];
        logic [WORD_W-1:0]     r_rd;
        logic [WORD_W-1:0]     w_wdata;
        logic [INDEX_BITS-1:0] w_waddr;
        logic                  w_wr;
        logic                  w_rd;

        assign w_wr    = !w_ready || (i_dccm_clken[b] && i_dccm_wren_bank[b]);
        assign w_rd    = w_ready && i_dccm_clken[b] && !i_dccm_wren_bank[b];
        assign w_waddr = w_ready ? i_dccm_addr_bank[b] : r_idx;
        assign w_wdata = w_ready ? {i_dccm_wr_ecc_bank[b], i_dccm_wr_data_bank[b]} : '0;

        always_ff @(posedge clk) begin
            if (!rst && w_wr)
                r_mem[w_waddr] <= w_wdata;
        end

        always_ff @(posedge clk) begin
            if (rst)
                r_rd <= '0;
            else if (w_rd)
                r_rd <= r_mem[i_dccm_addr_bank[b]] ^ w_flip[b];
        end

        assign o_dccm_bank_dout[b] = r_rd[DCCM_DATA_WIDTH-1:0];
        assign o_dccm_bank_ecc[b]  = r_rd[WORD_W-1:DCCM_DATA_WIDTH];
    end
endmodule

// File: tb/tb_el2_dccm_bank_ram.sv
// tb_el2_dccm_bank_ram: directed self-checking bench for el2_dccm_bank_ram.
// Covers the injector too when EL2_DCCM_ERR_INJ_EN is defined.
module tb_el2_dccm_bank_ram;
    localparam int NB = 4;
    localparam int DEPTH = 2048;
    localparam int DW = 32;
    localparam int EW = 7;
    localparam int IB = 11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NB-1:0] clken = '0;
    logic [NB-1:0] wren = '0;
    logic [NB-1:0][IB-1:0] addr = '0;
    logic [NB-1:0][DW-1:0] wdata = '0;
    logic [NB-1:0][EW-1:0] wecc = '0;
    logic [NB-1:0][DW-1:0] dout;
    logic [NB-1:0][EW-1:0] ecc;
    logic init_done;
`ifdef EL2_DCCM_ERR_INJ_EN
    logic inj_req = 1'b0;
    logic [1:0] inj_bank = '0;
    logic [5:0] inj_bit = '0;
`endif
    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    el2_dccm_bank_ram dut (
        .clk(clk),
        .rst(rst),
        .i_dccm_clken(clken),
        .i_dccm_wren_bank(wren),
        .i_dccm_addr_bank(addr),
        .i_dccm_wr_data_bank(wdata),
        .i_dccm_wr_ecc_bank(wecc),
`ifdef EL2_DCCM_ERR_INJ_EN
        .i_err_inj_req(inj_req),
        .i_err_inj_bank(inj_bank),
        .i_err_inj_bit(inj_bit),
`endif
        .o_dccm_bank_dout(dout),
        .o_dccm_bank_ecc(ecc),
        .o_init_done(init_done)
    );

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clken = '0;
        wren = '0;
    endtask

    task automatic op(input int b, input bit w, input logic [IB-1:0] a,
                      input logic [DW-1:0] d, input logic [EW-1:0] e);
        idle();
        clken[b] = 1'b1;
        wren[b] = w;
        addr[b] = a;
        wdata[b] = d;
        wecc[b] = e;
        step();
        idle();
    endtask

    task automatic wait_init(input string name);
        int n = 0;
        while (!init_done && n < 5000) begin
            step();
            n++;
        end
        n_tests++;
        if (n !== DEPTH) begin
            $display("FAIL %s: init_done rose after %0d cycles, expected %0d", name, n, DEPTH);
            n_fail++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        step();
        step();
        n_tests++;
        if (init_done !== 1'b0 || dout !== '0 || ecc !== '0) begin
            $display("FAIL reset_state: init_done=%b dout=%h ecc=%h, expected 0/0/0", init_done, dout, ecc);
            n_fail++;
        end
        rst = 1'b0;
        // Requests held for the whole sweep must all be ignored.
        clken = 4'b0011;
        wren = 4'b0001;
        addr[0] = 11'd5;
        addr[1] = 11'd5;
        wdata[0] = 32'h12345678;
        wecc[0] = 7'h7f;
        wait_init("init_cycles");
        idle();
        n_tests++;
        if (dout !== '0 || ecc !== '0) begin
            $display("FAIL init_outputs: dout=%h ecc=%h, expected 0", dout, ecc);
            n_fail++;
        end
    endtask

    task automatic test_init_ignored();
        clken = '1;
        wren = '0;
        addr[0] = 11'd5;
        addr[1] = 11'd0;
        addr[2] = 11'd2047;
        addr[3] = 11'd1000;
        step();
        idle();
        n_tests++;
        if (dout !== '0 || ecc !== '0) begin
            $display("FAIL init_zero_read: dout=%h ecc=%h, expected 0", dout, ecc);
            n_fail++;
        end
    endtask

    task automatic test_write_read();
        op(2, 1'b1, 11'h10, 32'hDEADBEEF, 7'h5A);
        n_tests++;
        if (dout[2] !== 32'h0) begin
            $display("FAIL no_write_through: dout[2]=%h, expected 0", dout[2]);
            n_fail++;
        end
        op(2, 1'b0, 11'h10, 32'h0, 7'h0);
        n_tests++;
        if (dout[2] !== 32'hDEADBEEF || ecc[2] !== 7'h5A) begin
            $display("FAIL write_read: dout[2]=%h ecc[2]=%h, expected deadbeef/5a", dout[2], ecc[2]);
            n_fail++;
        end
        n_tests++;
        if (dout[0] !== 32'h0 || dout[1] !== 32'h0 || dout[3] !== 32'h0) begin
            $display("FAIL other_banks: dout=%h, expected banks 0,1,3 zero", dout);
            n_fail++;
        end
    endtask

    task automatic test_multi_bank();
        clken = '1;
        wren = '1;
        for (int b = 0; b < NB; b++) begin
            addr[b] = IB'(b + 1);
            wdata[b] = 32'(b + 1) * 32'h11111111;
            wecc[b] = EW'(b + 1);
        end
        step();
        // Write enable without clock enable must not store.
        idle();
        wren[3] = 1'b1;
        wdata[3] = 32'h00000BAD;
        wecc[3] = 7'h7f;
        step();
        idle();
        clken = '1;
        for (int b = 0; b < NB; b++) addr[b] = IB'(b + 1);
        step();
        idle();
        for (int b = 0; b < NB; b++) begin
            n_tests++;
            if (dout[b] !== 32'(b + 1) * 32'h11111111 || ecc[b] !== EW'(b + 1)) begin
                $display("FAIL multi_read[%0d]: dout=%h ecc=%h, expected %h/%h", b, dout[b], ecc[b],
                         32'(b + 1) * 32'h11111111, EW'(b + 1));
                n_fail++;
            end
        end
        addr = '0;
        repeat (5) step();
        for (int b = 0; b < NB; b++) begin
            n_tests++;
            if (dout[b] !== 32'(b + 1) * 32'h11111111 || ecc[b] !== EW'(b + 1)) begin
                $display("FAIL multi_hold[%0d]: dout=%h ecc=%h, expected %h/%h", b, dout[b], ecc[b],
                         32'(b + 1) * 32'h11111111, EW'(b + 1));
                n_fail++;
            end
        end
    endtask

    task automatic test_back_to_back();
        idle();
        clken = 4'b0011;
        wren = 4'b0010;
        addr[0] = 11'd1;
        addr[1] = 11'd9;
        wdata[1] = 32'hA5A5A5A5;
        wecc[1] = 7'h33;
        step();
        wren = 4'b0001;
        wdata[0] = 32'hCAFEF00D;
        wecc[0] = 7'h44;
        step();
        idle();
        n_tests++;
        if (dout[1] !== 32'hA5A5A5A5 || ecc[1] !== 7'h33) begin
            $display("FAIL b2b_read: dout[1]=%h ecc[1]=%h, expected a5a5a5a5/33", dout[1], ecc[1]);
            n_fail++;
        end
        n_tests++;
        if (dout[0] !== 32'h11111111 || ecc[0] !== 7'h01) begin
            $display("FAIL b2b_hold: dout[0]=%h ecc[0]=%h, expected 11111111/01", dout[0], ecc[0]);
            n_fail++;
        end
        op(0, 1'b0, 11'd1, 32'h0, 7'h0);
        n_tests++;
        if (dout[0] !== 32'hCAFEF00D || ecc[0] !== 7'h44) begin
            $display("FAIL b2b_overwrite: dout[0]=%h ecc[0]=%h, expected cafef00d/44", dout[0], ecc[0]);
            n_fail++;
        end
    endtask

`ifdef EL2_DCCM_ERR_INJ_EN
    task automatic test_err_inj();
        inj_req = 1'b1;
        inj_bank = 2'd1;
        inj_bit = 6'd3;
        step();
        inj_req = 1'b0;
        op(2, 1'b0, 11'd100, 32'h0, 7'h0);
        n_tests++;
        if (dout[2] !== 32'h0) begin
            $display("FAIL inj_other_bank: dout[2]=%h, expected 0", dout[2]);
            n_fail++;
        end
        op(1, 1'b0, 11'd100, 32'h0, 7'h0);
        n_tests++;
        if (dout[1] !== 32'h8 || ecc[1] !== 7'h0) begin
            $display("FAIL inj_flip: dout[1]=%h ecc[1]=%h, expected 8/0", dout[1], ecc[1]);
            n_fail++;
        end
        op(1, 1'b0, 11'd100, 32'h0, 7'h0);
        n_tests++;
        if (dout[1] !== 32'h0) begin
            $display("FAIL inj_one_shot: dout[1]=%h, expected 0", dout[1]);
            n_fail++;
        end
        inj_req = 1'b1;
        step();
        inj_bit = 6'd32;
        step();
        inj_req = 1'b0;
        op(1, 1'b0, 11'd100, 32'h0, 7'h0);
        n_tests++;
        if (dout[1] !== 32'h0 || ecc[1] !== 7'h01) begin
            $display("FAIL inj_overwrite: dout[1]=%h ecc[1]=%h, expected 0/01", dout[1], ecc[1]);
            n_fail++;
        end
    endtask
`endif

    task automatic test_rst_mid_sweep();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_tests++;
        if (dout !== '0 || ecc !== '0 || init_done !== 1'b0) begin
            $display("FAIL rst_ready: dout=%h ecc=%h init_done=%b, expected 0", dout, ecc, init_done);
            n_fail++;
        end
        repeat (1000) step();
        n_tests++;
        if (init_done !== 1'b0) begin
            $display("FAIL mid_sweep_done: init_done=%b, expected 0", init_done);
            n_fail++;
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_init("resweep_cycles");
        op(2, 1'b0, 11'h10, 32'h0, 7'h0);
        n_tests++;
        if (dout[2] !== 32'h0 || ecc[2] !== 7'h0) begin
            $display("FAIL resweep_clear: dout[2]=%h ecc[2]=%h, expected 0", dout[2], ecc[2]);
            n_fail++;
        end
        op(0, 1'b0, 11'd1, 32'h0, 7'h0);
        n_tests++;
        if (dout[0] !== 32'h0 || ecc[0] !== 7'h0) begin
            $display("FAIL resweep_clear0: dout[0]=%h ecc[0]=%h, expected 0", dout[0], ecc[0]);
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_init_ignored();
        test_write_read();
        test_multi_bank();
        test_back_to_back();
`ifdef EL2_DCCM_ERR_INJ_EN
        test_err_inj();
`endif
        test_rst_mid_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
